// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NumReq producers.
// A producer owns the port for up to MaxBurst accepted beats, then ownership
// rotates. Writes are combinational from registered state so the FIFO
// captures on the same edge the producer sees its grant.
module fifo_wr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumReq-1:0]              req,
  input  logic [NumReq*DataWidth-1:0]    reqData,
  output logic [NumReq-1:0]              gnt,
  output logic                           writeEn,
  output logic [DataWidth-1:0]           writeData,
  input  logic                           full,
  output logic [$clog2(NumReq)-1:0]      owner,
  output logic                           busy
);

  localparam int OwW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [OwW-1:0]  owner_q, owner_d;
  logic [OwW-1:0]  last_q,  last_d;
  logic [CntW-1:0] cnt_q,   cnt_d;

  // First set request strictly after 'base', wrapping; base itself is
  // checked last. Returns base when nothing is requesting (caller gates).
  function automatic logic [OwW-1:0] rr_pick(input logic [NumReq-1:0] r,
                                             input logic [OwW-1:0]    base);
    logic [OwW-1:0] pick;
    int             idx;
    pick = base;
    for (int k = NumReq; k >= 1; k--) begin
      idx = (int'(base) + k) % NumReq;
      if (r[idx]) pick = OwW'(idx);
    end
    return pick;
  endfunction

  // Per-requester accept strobe: only the owner can be accepted, so gnt is
  // one-hot or zero by construction, and full blocks it in the same cycle.
  for (genvar i = 0; i < NumReq; i++) begin : g_gnt
    assign gnt[i] = (state_q == GRANT) && (owner_q == OwW'(i)) && req[i] && !full;
  end

  assign writeEn   = |gnt;
  assign writeData = writeEn ? reqData[int'(owner_q)*DataWidth +: DataWidth]
                             : '0;
  assign owner     = owner_q;
  assign busy      = (state_q == GRANT);

  // Next-state: pick from IDLE, count beats in GRANT, release on burst end or
  // request drop and re-pick in the same cycle so grants run back to back.
  always_comb begin
    logic release_now;
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    release_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          owner_d = rr_pick(req, last_q);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          release_now = 1'b1;
        end else if (writeEn) begin
          if (cnt_q == CntW'(MaxBurst - 1)) release_now = 1'b1;
          else                              cnt_d = cnt_q + CntW'(1);
        end
        // full with a live request stalls: everything holds.
        if (release_now) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (|req) begin
            state_d = GRANT;
            owner_d = rr_pick(req, owner_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; requester 0 gets first priority out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OwW'(NumReq - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: a cycle model of the arbitration rules pushes the
// expected outputs each cycle; a separate monitor pops and compares.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] reqData = '0;
  logic            full = 1'b0;
  logic [N-1:0]    gnt;
  logic            writeEn;
  logic [DW-1:0]   writeData;
  logic [OW-1:0]   owner;
  logic            busy;

  fifo_wr_arbiter #(.NumReq(N), .DataWidth(DW), .MaxBurst(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(reqData), .gnt(gnt),
    .writeEn(writeEn), .writeData(writeData), .full(full),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] wd;
    logic          busy;
    logic          chk_owner;
    logic [OW-1:0] owner;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which producer holds the port, how many beats it has
  // written in this grant, and who held it last.
  bit m_active = 0;
  int m_owner  = 0;
  int m_last   = N - 1;
  int m_cnt    = 0;

  function automatic int next_after(input int base);
    for (int k = 1; k <= N; k++)
      if (req[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    exp_t e;
    int   p;
    if (!rst) begin
      e.gnt = '0; e.wd = '0; e.busy = 1'b0; e.chk_owner = 1'b1; e.owner = '0;
      m_active = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    end else begin
      e.busy = m_active; e.chk_owner = m_active; e.owner = OW'(m_owner);
      e.gnt = '0; e.wd = '0;
      if (m_active && req[m_owner] && !full) begin
        e.gnt[m_owner] = 1'b1;
        e.wd = reqData[m_owner*DW +: DW];
      end
      if (!m_active) begin
        p = next_after(m_last);
        if (p >= 0) begin m_active = 1; m_owner = p; m_cnt = 0; end
      end else if (!req[m_owner] || (!full && (m_cnt + 1 == MB))) begin
        m_last = m_owner;
        p = next_after(m_owner);
        if (p >= 0) begin m_owner = p; m_cnt = 0; end
        else m_active = 0;
      end else if (!full) begin
        m_cnt++;
      end
    end
    sbq.push_back(e);
  end

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("gnt", 64'(gnt), 64'(e.gnt));
      chk("writeEn", 64'(writeEn), 64'(|e.gnt));
      chk("writeData", 64'(writeData), 64'(e.wd));
      chk("busy", 64'(busy), 64'(e.busy));
      if (e.chk_owner) chk("owner", 64'(owner), 64'(e.owner));
      chk("no_write_when_full", 64'(writeEn & full), 64'd0);
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    end
  end

  int seq [N];

  task automatic set_data(input int i);
    seq[i]++;
    reqData[i*DW +: DW] = {8'(i), 24'(seq[i])};
  endtask

  // One cycle of producer behaviour: hold until granted, then maybe continue
  // with fresh data; idle producers may start, waiting ones may give up.
  task automatic cyc(input int keep, input int start, input int drop,
                     input int fullp, input logic [N-1:0] allow);
    logic [N-1:0] g;
    @(negedge clk); g = gnt;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (req[i] && g[i]) begin
        if (int'($urandom % 100) < keep) set_data(i); else req[i] = 1'b0;
      end else if (req[i]) begin
        if (int'($urandom % 100) < drop) req[i] = 1'b0;
      end else if (allow[i] && int'($urandom % 100) < start) begin
        set_data(i);
        req[i] = 1'b1;
      end
    end
    full = (int'($urandom % 100) < fullp);
  endtask

  task automatic drain();
    repeat (4) cyc(0, 0, 100, 0, '0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit seen;
    for (int i = 0; i < N; i++) seq[i] = 0;
    repeat (3) cyc(0, 0, 0, 0, '0);
    rst = 1'b1;

    repeat (10) cyc(100, 100, 0, 0, 4'b0010);   // single requester burst
    drain();
    repeat (24) cyc(100, 100, 0, 0, 4'b1111);   // rotation
    drain();
    repeat (30) cyc(100, 100, 0, 30, 4'b1111);  // full stalls
    drain();
    repeat (40) cyc(70, 50, 20, 10, 4'b1111);   // request drops
    drain();
    repeat (2000) cyc(60, 40, 5, 20, 4'b1111);  // random mix
    drain();

    // Reset mid-burst: outputs must fall without waiting for a clock.
    repeat (6) cyc(100, 100, 0, 0, 4'b1111);
    rst = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_writeEn", 64'(writeEn), 64'd0);
    chk("rst_writeData", 64'(writeData), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    req  = 4'b1010;
    full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk); #2;
      if (writeEn) begin
        seen = 1;
        chk("first_gnt_after_reset", 64'(gnt), 64'd2);
      end
    end
    if (!seen) chk("first_gnt_timeout", 64'd0, 64'd1);

    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
